// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART Tx scheduler and Tx path.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int WIDTH_SIZE_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_ACCEPT = 2'd1,
      WAIT_DONE   = 2'd2
   } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, scanning upward from last grant + 1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_last,
   output logic [NUM_REQ-1:0]         o_grant,
   output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
   output logic                       o_any_req
);

   localparam int c_idx_w = $clog2(NUM_REQ);

   always_comb begin : p_scan
      int cand;
      o_grant     = '0;
      o_grant_idx = '0;
      o_any_req   = 1'b0;
      cand        = 0;
      // Offset NUM_REQ wraps back to the last winner, so it is checked last.
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(i_last) + k) % NUM_REQ;
         if (!o_any_req && i_req[cand]) begin
            o_any_req      = 1'b1;
            o_grant[cand]  = 1'b1;
            o_grant_idx    = c_idx_w'(cand);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Brief    : Round-robin sharing of one UART Tx path, one frame per grant,
//            with watchdog abort and completed-frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH_SIZE = WIDTH_SIZE_DEFAULT,
   parameter int TIMEOUT    = 64,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*WIDTH_SIZE-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_err,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          cfg_pf,
   output logic                          tx_valid,
   output logic [WIDTH_SIZE-1:0]         tx_data,
   output logic                          tx_err,
   output logic                          tx_pf,
   input  logic                          tx_ready,
   output logic                          busy,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          done_pulse,
   output logic                          timeout_err,
   output logic [CNT_W-1:0]              frame_count
);

   localparam int                c_idx_w   = $clog2(NUM_REQ);
   localparam int                c_wd_w    = $clog2(TIMEOUT);
   localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

   ctrl_state_t             r_state;
   ctrl_state_t             w_state_nxt;
   logic [c_wd_w-1:0]       r_wd;
   logic [NUM_REQ-1:0]      r_req_ready;
   logic                    r_tx_valid;
   logic [WIDTH_SIZE-1:0]   r_data;
   logic                    r_err;
   logic                    r_pf;
   logic                    r_busy;
   logic [c_idx_w-1:0]      r_grant_id;
   logic                    r_done;
   logic                    r_timeout;
   logic [CNT_W-1:0]        r_count;

   logic [NUM_REQ-1:0]      w_arb_grant;
   logic [c_idx_w-1:0]      w_arb_idx;
   logic                    w_any_req;
   logic                    w_grant_ok;
   logic                    w_wd_expire;
   logic                    w_done_nxt;
   logic                    w_timeout_nxt;
   logic                    w_tx_valid_nxt;
   logic                    w_busy_nxt;
   logic [NUM_REQ-1:0]      w_req_ready_nxt;
   logic [WIDTH_SIZE-1:0]   w_words [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_words[gi] = req_data[gi*WIDTH_SIZE +: WIDTH_SIZE];
   end

   rr_arbiter #(
      .NUM_REQ     (NUM_REQ)
   ) u_arb (
      .i_req       (req_valid),
      .i_last      (r_grant_id),
      .o_grant     (w_arb_grant),
      .o_grant_idx (w_arb_idx),
      .o_any_req   (w_any_req)
   );

   assign w_grant_ok  = (r_state == IDLE) && tx_ready && w_any_req;
   assign w_wd_expire = (r_wd == c_wd_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Watchdog abort takes precedence over handshake progress in the same cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:        if (w_grant_ok)  w_state_nxt = WAIT_ACCEPT;
         WAIT_ACCEPT: if (w_wd_expire) w_state_nxt = IDLE;
                      else if (!tx_ready) w_state_nxt = WAIT_DONE;
         WAIT_DONE:   if (w_wd_expire) w_state_nxt = IDLE;
                      else if (tx_ready) w_state_nxt = IDLE;
         default:     w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_done_nxt      = (r_state == WAIT_DONE) && !w_wd_expire && tx_ready;
      w_timeout_nxt   = ((r_state == WAIT_ACCEPT) || (r_state == WAIT_DONE)) && w_wd_expire;
      w_tx_valid_nxt  = (w_state_nxt == WAIT_ACCEPT);
      w_busy_nxt      = (w_state_nxt != IDLE);
      w_req_ready_nxt = w_grant_ok ? w_arb_grant : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wd        <= '0;
         r_req_ready <= '0;
         r_tx_valid  <= 1'b0;
         r_data      <= '0;
         r_err       <= 1'b0;
         r_pf        <= 1'b0;
         r_busy      <= 1'b0;
         r_grant_id  <= c_idx_w'(NUM_REQ - 1);
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_count     <= '0;
      end else begin
         if ((w_state_nxt == IDLE) || (w_state_nxt != r_state)) r_wd <= '0;
         else                                                   r_wd <= r_wd + 1'b1;
         if (w_grant_ok) begin
            r_data     <= w_words[w_arb_idx];
            r_err      <= req_err[w_arb_idx];
            r_pf       <= cfg_pf;
            r_grant_id <= w_arb_idx;
         end
         r_req_ready <= w_req_ready_nxt;
         r_tx_valid  <= w_tx_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_timeout   <= w_timeout_nxt;
         if (w_done_nxt) r_count <= r_count + 1'b1;
      end
   end

   assign req_ready   = r_req_ready;
   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_data;
   assign tx_err      = r_err;
   assign tx_pf       = r_pf;
   assign busy        = r_busy;
   assign grant_id    = r_grant_id;
   assign done_pulse  = r_done;
   assign timeout_err = r_timeout;
   assign frame_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Brief    : Scheduler driving a behavioural 1-bit-per-clock Tx path; the
//            serial line is decoded and compared with a round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int TMO  = 64;
   localparam int CW   = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     req_valid = '0;
   logic [31:0]    req_data = '0;
   logic [3:0]     req_err = '0;
   logic           cfg_pf = 1'b0;
   logic [3:0]     req_ready;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic           tx_err;
   logic           tx_pf;
   logic           tx_ready;
   logic           busy;
   logic [1:0]     grant_id;
   logic           done_pulse;
   logic           timeout_err;
   logic [CW-1:0]  frame_count;
   logic           stub_mode = 1'b0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(
      .NUM_REQ(NREQ), .WIDTH_SIZE(W), .TIMEOUT(TMO), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_err(req_err), .req_ready(req_ready), .cfg_pf(cfg_pf),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_err(tx_err), .tx_pf(tx_pf),
      .tx_ready(tx_ready), .busy(busy), .grant_id(grant_id),
      .done_pulse(done_pulse), .timeout_err(timeout_err), .frame_count(frame_count)
   );

   // Tx path: sees valid, samples a cycle later, then start/8 data/parity/stop.
   logic [1:0]  m_phase;
   logic        m_ready;
   logic        m_line;
   int          m_bitpos;
   logic [10:0] m_frame;

   assign tx_ready = stub_mode | m_ready;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_phase <= 2'd0; m_ready <= 1'b1; m_line <= 1'b1; m_bitpos <= 0; m_frame <= '0;
      end else begin
         case (m_phase)
            2'd0: if (tx_valid && !stub_mode) m_phase <= 2'd1;
            2'd1: begin
               m_frame  <= {1'b1, (^tx_data) ^ tx_err, tx_data, 1'b0};
               m_line   <= 1'b0;
               m_ready  <= 1'b0;
               m_bitpos <= 1;
               m_phase  <= 2'd2;
            end
            default: begin
               if (m_bitpos == 11) begin
                  m_line <= 1'b1; m_ready <= 1'b1; m_phase <= 2'd0;
               end else begin
                  m_line   <= m_frame[m_bitpos];
                  m_bitpos <= m_bitpos + 1;
               end
            end
         endcase
      end
   end

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         to_cnt = 0;
   int         ref_last = 3;
   int         ref_count = 0;
   logic [3:0] hold_mask = '0;
   logic       prev_txv = 1'b0;
   logic [3:0] rr_q[$];
   int         done_q[$];
   int         txv_q[$];
   logic [9:0] dec_q[$];
   logic       dec_active = 1'b0;
   int         dec_n = 0;
   logic [9:0] dec_bits = '0;

   function automatic int rr_pick(input logic [3:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [9:0] exp_frame(input logic [7:0] d, input logic e);
      return {1'b1, (^d) ^ e, d};
   endfunction

   function automatic logic [3:0] onehot(input int i);
      logic [3:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   // One cycle: observe at the falling edge, log events, free served requesters.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (req_ready != 4'b0) begin
         rr_q.push_back(req_ready);
         req_valid = req_valid & ~(req_ready & ~hold_mask);
      end
      if (done_pulse) done_q.push_back(cyc);
      if (timeout_err) to_cnt++;
      if (tx_valid && !prev_txv) txv_q.push_back(cyc);
      prev_txv = tx_valid;
      if (dec_active) begin
         dec_bits[dec_n] = m_line;
         dec_n++;
         if (dec_n == 10) begin
            dec_q.push_back(dec_bits);
            dec_active = 1'b0;
         end
      end else if (m_line == 1'b0) begin
         dec_active = 1'b1;
         dec_n = 0;
      end
   endtask

   task automatic clear_logs();
      rr_q.delete(); done_q.delete(); txv_q.delete(); dec_q.delete();
      to_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      dec_active = 1'b0;
      prev_txv = 1'b0;
      ref_last = 3;
      ref_count = 0;
      clear_logs();
   endtask

   task automatic run_frames(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick();
         if (done_q.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   // Replays the pending set through the round-robin rule and checks each grant and frame.
   task automatic check_grants(input string name, input logic [3:0] pend_in, input int n);
      logic [3:0] pend;
      int e;
      pend = pend_in;
      for (int i = 0; i < n; i++) begin
         e = rr_pick(pend, ref_last);
         checks++;
         if (i >= rr_q.size() || rr_q[i] !== onehot(e)) begin
            errors++;
            $display("FAIL %s_grant%0d: got %b required %b", name, i,
                     (i < rr_q.size()) ? rr_q[i] : 4'b0, onehot(e));
         end
         checks++;
         if (i >= dec_q.size() || dec_q[i] !== exp_frame(req_data[e*8 +: 8], req_err[e])) begin
            errors++;
            $display("FAIL %s_line%0d: got %b required %b", name, i,
                     (i < dec_q.size()) ? dec_q[i] : 10'b0, exp_frame(req_data[e*8 +: 8], req_err[e]));
         end
         if (!hold_mask[e]) pend[e] = 1'b0;
         ref_last = e;
         ref_count++;
      end
   endtask

   task automatic test_reset();
      logic [22:0] got;
      tick(); tick();
      got = {req_ready, tx_valid, tx_data, tx_err, tx_pf, busy, grant_id, done_pulse, timeout_err, frame_count};
      checks++;
      if (got !== {4'b0, 1'b0, 8'h00, 3'b000, 2'd3, 2'b00, 3'd0}) begin
         errors++;
         $display("FAIL reset_outputs: got %h required %h", got, {4'b0, 1'b0, 8'h00, 3'b000, 2'd3, 2'b00, 3'd0});
      end
      reset = 1'b0;
      tick(); tick(); tick();
      checks++;
      if (busy !== 1'b0 || req_ready !== 4'b0 || rr_q.size() != 0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b req_ready=%b grants=%0d required 0/0000/0", busy, req_ready, rr_q.size());
      end
   endtask

   task automatic test_single();
      bit ok;
      clear_logs();
      hold_mask = '0;
      req_data[7:0] = 8'hA5; req_err = '0; cfg_pf = 1'b0; req_valid = 4'b0001;
      run_frames(1, 100, ok);
      tick(); tick();
      checks++;
      if (!ok || done_q.size() != 1) begin
         errors++;
         $display("FAIL single_done: got %0d done pulses required 1", done_q.size());
      end
      check_grants("single", 4'b0001, 1);
      checks++;
      if (frame_count !== CW'(ref_count)) begin
         errors++;
         $display("FAIL single_count: got %0d required %0d", frame_count, CW'(ref_count));
      end
   endtask

   task automatic test_all_four();
      bit ok;
      do_reset();
      hold_mask = '0;
      req_data = {8'h44, 8'h33, 8'h22, 8'h11}; req_err = '0;
      req_valid = 4'b1111;
      run_frames(4, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL all4_done: got %0d done pulses required 4", done_q.size());
      end
      check_grants("all4", 4'b1111, 4);
      req_valid = 4'b0001;
      run_frames(5, 100, ok);
      tick();
      checks++;
      if (!ok || rr_q.size() != 5 || rr_q[4] !== onehot(rr_pick(4'b0001, ref_last))) begin
         errors++;
         $display("FAIL all4_regrant0: got %0d grants last=%b required 5 with %b", rr_q.size(),
                  (rr_q.size() > 0) ? rr_q[rr_q.size()-1] : 4'b0, onehot(rr_pick(4'b0001, ref_last)));
      end
      ref_last = 0; ref_count++;
      checks++;
      if (frame_count !== CW'(ref_count)) begin
         errors++;
         $display("FAIL all4_count: got %0d required %0d", frame_count, CW'(ref_count));
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_logs();
      hold_mask = 4'b1010;
      req_data[15:8] = 8'($urandom); req_data[31:24] = 8'($urandom);
      req_valid = 4'b1010;
      run_frames(4, 300, ok);
      req_valid = '0;
      tick(); tick(); tick();
      checks++;
      if (!ok || rr_q.size() != 4) begin
         errors++;
         $display("FAIL b2b_grants: got %0d grants required 4", rr_q.size());
      end
      check_grants("b2b", 4'b1010, 4);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i + 1 >= txv_q.size() || i >= done_q.size() || txv_q[i+1] != done_q[i] + 1) begin
            errors++;
            $display("FAIL b2b_gap%0d: tx_valid rise at %0d required %0d", i,
                     (i + 1 < txv_q.size()) ? txv_q[i+1] : -1, (i < done_q.size()) ? done_q[i] + 1 : -1);
         end
      end
      checks++;
      if (frame_count !== CW'(ref_count)) begin
         errors++;
         $display("FAIL b2b_count_wrap: got %0d required %0d", frame_count, CW'(ref_count));
      end
      hold_mask = '0;
   endtask

   task automatic test_err_inject();
      bit flipped, err_bad, pf_bad;
      clear_logs();
      flipped = 1'b0; err_bad = 1'b0; pf_bad = 1'b0;
      req_data[23:16] = 8'h0F; req_err = 4'b0100; cfg_pf = 1'b1;
      req_valid = 4'b0100;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (rr_q.size() > 0 && !flipped) begin
            cfg_pf = 1'b0; flipped = 1'b1;
         end
         if (busy && (tx_err !== 1'b1 || tx_data !== 8'h0F)) err_bad = 1'b1;
         if (busy && tx_pf !== 1'b1) pf_bad = 1'b1;
         if (done_q.size() > 0) break;
      end
      checks++;
      if (done_q.size() != 1) begin
         errors++;
         $display("FAIL err_done: got %0d done pulses required 1", done_q.size());
      end
      check_grants("err", 4'b0100, 1);
      req_err = '0;
      checks++;
      if (err_bad) begin
         errors++;
         $display("FAIL err_stable: tx_err/tx_data changed mid-frame, required 1/0f throughout");
      end
      checks++;
      if (pf_bad) begin
         errors++;
         $display("FAIL err_pf_latched: tx_pf changed with cfg_pf, required 1 throughout");
      end
   endtask

   task automatic test_timeout();
      int         cnt_before;
      int         to_cyc;
      logic       busy_at, txv_at;
      cnt_before = int'(frame_count);
      clear_logs();
      to_cyc = -1; busy_at = 1'b1; txv_at = 1'b1;
      stub_mode = 1'b1;
      req_valid = 4'b0001;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (to_cnt > 0) begin
            to_cyc = cyc; busy_at = busy; txv_at = tx_valid;
            break;
         end
      end
      tick(); tick(); tick();
      checks++;
      if (to_cyc < 0 || txv_q.size() == 0 || to_cyc - txv_q[0] != TMO) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles required %0d", (to_cyc >= 0 && txv_q.size() > 0) ? to_cyc - txv_q[0] : -1, TMO);
      end
      checks++;
      if (to_cnt != 1 || done_q.size() != 0) begin
         errors++;
         $display("FAIL timeout_pulses: timeout=%0d done=%0d required 1/0", to_cnt, done_q.size());
      end
      checks++;
      if (int'(frame_count) != cnt_before) begin
         errors++;
         $display("FAIL timeout_count: got %0d required %0d", frame_count, cnt_before);
      end
      checks++;
      if (busy_at !== 1'b0 || txv_at !== 1'b0) begin
         errors++;
         $display("FAIL timeout_idle: busy=%b tx_valid=%b required 0/0", busy_at, txv_at);
      end
      ref_last = 0;
      stub_mode = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      logic [22:0] got;
      clear_logs();
      req_data[15:8] = 8'h5A;
      req_valid = 4'b0010;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (busy && !tx_valid) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midrst_reach_wait_done: busy=%b tx_valid=%b required 1/0", busy, tx_valid);
      end
      #2 reset = 1'b1;
      #1;
      got = {req_ready, tx_valid, tx_data, tx_err, tx_pf, busy, grant_id, done_pulse, timeout_err, frame_count};
      checks++;
      if (got !== {4'b0, 1'b0, 8'h00, 3'b000, 2'd3, 2'b00, 3'd0}) begin
         errors++;
         $display("FAIL midrst_outputs: got %h required %h", got, {4'b0, 1'b0, 8'h00, 3'b000, 2'd3, 2'b00, 3'd0});
      end
      @(negedge clk); @(negedge clk);
      req_data = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      req_valid = 4'b1111;
      reset = 1'b0;
      dec_active = 1'b0; prev_txv = 1'b0;
      ref_last = 3; ref_count = 0;
      clear_logs();
      run_frames(4, 300, ok);
      tick(); tick();
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL midrst_done: got %0d done pulses required 4", done_q.size());
      end
      check_grants("midrst", 4'b1111, 4);
      checks++;
      if (frame_count !== CW'(ref_count)) begin
         errors++;
         $display("FAIL midrst_count: got %0d required %0d", frame_count, CW'(ref_count));
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_back_to_back();
      test_err_inject();
      test_timeout();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: simulation exceeded 200000 time units");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
